// File: rtl/fifo_pkg.sv
// Shared constants and lane-mask helper for the read-side packer.
// Defaults match the Async_FIFO instantiation.
package fifo_pkg;

   localparam int DEF_DATA_LINES = 8;
   localparam int DEF_PACK       = 4;
   localparam int MAX_PACK       = 64;

   typedef logic [MAX_PACK-1:0] mask_t;

   // Ones in the low 'count' lanes, zeros above.
   function automatic mask_t keep_mask(input int count);
      mask_t m;
      m = '0;
      for (int k = 0; k < MAX_PACK; k++) begin
         if (k < count) m[k] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Packed-word valid/ready stream between the packer and
// the downstream datapath.
interface fifo_rd_packer_if #(
   parameter int DATA_LINES = 8,
   parameter int PACK       = 4
);

   logic [PACK*DATA_LINES-1:0] out_data;
   logic [PACK-1:0]            out_keep;
   logic                       out_valid;
   logic                       out_ready;

   modport master (
      output out_data,
      output out_keep,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_keep,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/pack_out_reg.sv
// Single-entry output register holding one packed word
// until the downstream handshake takes it.
module pack_out_reg
   import fifo_pkg::*;
#(
   parameter int DATA_LINES = DEF_DATA_LINES,
   parameter int PACK       = DEF_PACK
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic [PACK*DATA_LINES-1:0] load_data,
   input  logic [PACK-1:0]            load_keep,
   output logic                       accept,
   fifo_rd_packer_if.master           os
);

   // Register is free when empty or being drained this edge.
   always_comb begin
      accept = !os.out_valid || os.out_ready;
   end

   // Load a new word, or drop valid once the held word transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         os.out_valid <= 1'b0;
         os.out_data  <= '0;
         os.out_keep  <= '0;
      end else if (load) begin
         os.out_valid <= 1'b1;
         os.out_data  <= load_data;
         os.out_keep  <= load_keep;
      end else if (os.out_ready) begin
         os.out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries in the read domain and packs PACK of them,
// little-endian, into one word; flush emits a partial word.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int  DATA_LINES = DEF_DATA_LINES,
   parameter int  PACK       = DEF_PACK,
   localparam int CNT_W      = $clog2(PACK+1)
) (
   input  logic                  rclk,
   input  logic                  rrst,
   input  logic                  rempty,
   input  logic [DATA_LINES-1:0] rdata,
   output logic                  rinc,
   input  logic                  flush,
   output logic [CNT_W-1:0]      fill_cnt,
   fifo_rd_packer_if.master      os
);

   typedef logic [PACK-1:0][DATA_LINES-1:0] lanes_t;

   lanes_t                     lanes;
   lanes_t                     lanes_cap;
   logic [CNT_W-1:0]           cnt;
   logic [CNT_W-1:0]           cnt_cap;
   logic                       flush_pend;
   logic                       flush_pend_n;
   logic                       accept;
   logic                       full;
   logic                       fl;
   logic                       load;
   logic [PACK*DATA_LINES-1:0] load_data;
   logic [PACK-1:0]            load_keep;

   assign fill_cnt = cnt;

   // Pop unless the word would complete with nowhere to go.
   always_comb begin
      rinc = !rempty && !rrst &&
             (cnt < CNT_W'(PACK-1) || accept);
   end

   // Lane capture and word/flush emission decision.
   always_comb begin
      lanes_cap = lanes;
      cnt_cap   = cnt;
      if (rinc) begin
         for (int k = 0; k < PACK; k++) begin
            if (cnt == CNT_W'(k)) lanes_cap[k] = rdata;
         end
         cnt_cap = cnt + 1'b1;
      end
      full         = rinc && (cnt == CNT_W'(PACK-1));
      fl           = flush || flush_pend;
      load         = full || (fl && accept && cnt_cap != '0);
      load_data    = lanes_cap;
      load_keep    = PACK'(keep_mask(int'(cnt_cap)));
      flush_pend_n = fl && !load && cnt_cap != '0;
   end

   // Pack buffer, lane counter and pending flush; cleared
   // lanes keep unused output lanes at zero.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         lanes      <= '0;
         cnt        <= '0;
         flush_pend <= 1'b0;
      end else begin
         if (load) begin
            lanes <= '0;
            cnt   <= '0;
         end else begin
            lanes <= lanes_cap;
            cnt   <= cnt_cap;
         end
         flush_pend <= flush_pend_n;
      end
   end

   pack_out_reg #(
      .DATA_LINES(DATA_LINES),
      .PACK      (PACK)
   ) u_out (
      .clk      (rclk),
      .rst      (rrst),
      .load     (load),
      .load_data(load_data),
      .load_keep(load_keep),
      .accept   (accept),
      .os       (os)
   );

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the async FIFO, in the rclk domain.
- Pops DATA_LINES-bit entries from the FIFO read port and packs PACK consecutive entries into one wide word, little-endian.
- Presents the packed word on a valid/ready stream to the downstream datapath.
- A flush input forces out a partially packed word, with a per-lane keep mask.

Parameters:
- DATA_LINES, 8: width of one FIFO entry.
- PACK, 4: FIFO entries per output word; legal values ≥2.
- CNT_W, $clog2(PACK+1): width of the fill counter (derived; do not override).

Ports:
- rclk  input  1  read-domain clock.
- rrst  input  1  synchronous, active-high reset.
- rempty  input  1  FIFO empty flag (rclk domain).
- rdata  input  DATA_LINES  FIFO head entry; valid whenever rempty=0.
- rinc  output  1  pop strobe to the FIFO; one entry consumed per rclk edge while high.
- flush  input  1  single-cycle request to emit the current partial word.
- out_data  output  PACK*DATA_LINES  packed word; entry k occupies bits [k*DATA_LINES +: DATA_LINES].
- out_keep  output  PACK  bit k=1 means lane k holds valid data.
- out_valid  output  1  out_data/out_keep valid.
- out_ready  input  1  downstream accepts the word when out_valid&&out_ready at an rclk edge.
- fill_cnt  output  CNT_W  number of lanes currently captured in the pack buffer (debug/status).

Behaviour:
- Reset: all regs update on the rclk edge when rrst=1; no asynchronous path.
  - After reset: rinc=0, out_valid=0, out_data=0, out_keep=0, fill_cnt=0, flush_pend=0.
  - rrst mid-operation discards any partial word and any held output word.
- Internal state: pack buffer (PACK lanes), lane index cnt, output register, and flush_pend flag.
- accept = (!out_valid || out_ready): the output register can take a word this cycle.
- rinc (combinational) = !rempty && !rrst && (cnt < PACK-1 || accept).
  - When the buffer is about to complete, popping is allowed only if the completed word can move to the output register in the same edge.
- On rinc: rdata is written into lane cnt, then cnt+1.
  - If the new cnt == PACK, the word moves to the output register: out_keep = all ones, out_valid=1, cnt=0.
  - Zero-bubble: a full word is emitted in the same edge as the last pop.
- Flush:
  - flush=1 sets flush_pend; flush_pend persists until the partial word is emitted.
  - Emission occurs on the first edge where accept=1 and cnt>0 (counting any lane captured that same edge).
  - On emission: out_keep[k]=1 for k < captured count, 0 for the rest; unused lanes in out_data are 0; cnt=0; flush_pend=0.
  - flush with cnt==0 and no pop that cycle: no word is emitted, flush_pend cleared.
  - flush in the same cycle the word completes to PACK: the full word is emitted normally, flush_pend cleared; no empty word is emitted.
- Output handshake:
  - out_valid=1 holds out_data/out_keep stable until out_valid&&out_ready.
  - When a transfer occurs and no new word is loaded that edge, out_valid goes to 0.
  - Back-to-back words are sustained: with a FIFO that never goes empty and out_ready=1, the throughput is one word every PACK cycles.
- rempty=1: rinc=0; the partial word is held indefinitely until more data arrives or flush.
- Latency: from the pop of the last lane to out_valid=1 is 1 rclk edge.
- Wrap-around: cnt counts 0..PACK-1 and returns to 0 on emission; it never exceeds PACK-1 at rest.
- fill_cnt = cnt.

Decomposition:
- Package fifo_pkg holds the lane-mask helper function keep_mask(count) and default DATA_LINES/PACK constants shared with Async_FIFO instantiation.
- One natural sub-module: pack_out_reg, a single-entry valid/ready output register with load/accept logic.
- The pack buffer and counter live in the top module.

Test Plan:
- Reset, then push 8'h11,22,33,44 with out_ready=1 → rinc high 4 cycles; out_data=32'h44332211, out_keep=4'hF, out_valid for 1 cycle one edge after the 4th pop.
- Push 8 bytes 01..08 continuously, out_ready=1 → words 32'h04030201 then 32'h08070605; second out_valid exactly 4 cycles after first; no idle pop cycles.
- Push AA,BB then FIFO empty, pulse flush → out_data=32'h0000BBAA, out_keep=4'b0011; fill_cnt returns to 0.
- Complete word with out_ready=0 and more FIFO data → out_valid held with data stable; rinc stops when cnt=3; raising out_ready yields the transfer and the next pop the same edge.
- flush pulsed with cnt=0 and FIFO empty → no out_valid; flush in same cycle as 4th pop → single word with out_keep=4'hF.
- Assert rrst with cnt=2 and out_valid=1 → next edge out_valid=0, fill_cnt=0, out_data=0; the next bytes pack starting at lane 0.
